// File: rtl/seq_match_scheduler.sv
// Shares one serial pattern-match engine between N_REQ requesters with round-robin grants.
// Latency: the grant lands one cycle after req; done lands one cycle after the matching/timeout bit.
// Backpressure: din is consumed only while a session is hunting; bits arriving in IDLE/DONE are dropped.
//
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   req[N_REQ]          - level request per requester, held until done
//   pattern             - requester i pattern at [i*PAT_W +: PAT_W], MSB = oldest bit
//   din, din_valid      - serial bitstream and its qualifier
//   abort               - only when SEQ_MATCH_SCHED_ABORT_EN is defined: ends the hunt without a hit
//   gnt                 - one-hot grant, held through the DONE cycle
//   busy                - session active (HUNT or DONE)
//   done                - one-cycle session-complete pulse
//   hit, match_pos, done_id - session result, valid with done
//
// Optional feature macro: SEQ_MATCH_SCHED_ABORT_EN (adds the abort input).

module seq_match_scheduler #(
   parameter int N_REQ    = 4,
   parameter int PAT_W    = 5,
   parameter int MAX_BITS = 64,
   localparam int ID_W    = $clog2(N_REQ),
   localparam int POS_W   = $clog2(MAX_BITS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*PAT_W-1:0] pattern,
   input  logic                   din,
   input  logic                   din_valid,
`ifdef SEQ_MATCH_SCHED_ABORT_EN
   input  logic                   abort,
`endif
   output logic [N_REQ-1:0]       gnt,
   output logic                   busy,
   output logic                   done,
   output logic                   hit,
   output logic [POS_W-1:0]       match_pos,
   output logic [ID_W-1:0]        done_id
);

   localparam int FILL_W = $clog2(PAT_W + 1);

   localparam logic [POS_W-1:0]  LAST_BIT = POS_W'(MAX_BITS - 1);
   localparam logic [FILL_W-1:0] FILL_MIN = FILL_W'(PAT_W - 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HUNT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state, state_d;
   logic [ID_W-1:0]     ptr, ptr_d;
   logic [ID_W-1:0]     sess_id, sess_id_d;
   logic [PAT_W-1:0]    pat_q, pat_d;
   logic [PAT_W-1:0]    shift, shift_d;
   logic [FILL_W-1:0]   fill, fill_d;
   logic [POS_W-1:0]    bit_cnt, bit_cnt_d;

   logic [N_REQ-1:0]    gnt_d;
   logic                busy_d;
   logic                done_d;
   logic                hit_d;
   logic [POS_W-1:0]    match_pos_d;
   logic [ID_W-1:0]     done_id_d;

   logic                abort_w;
   logic                arb_found;
   logic [ID_W-1:0]     arb_id;
   logic [PAT_W-1:0]    window;

`ifdef SEQ_MATCH_SCHED_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   // Window as it would look after shifting in the current din bit.
   assign window = {shift[PAT_W-2:0], din};

   // Round-robin search starting just after the last granted id.
   always_comb begin
      arb_found = 1'b0;
      arb_id    = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!arb_found && req[(int'(ptr) + k) % N_REQ]) begin
            arb_found = 1'b1;
            arb_id    = ID_W'((int'(ptr) + k) % N_REQ);
         end
      end
   end

   always_comb begin
      state_d     = state;
      ptr_d       = ptr;
      sess_id_d   = sess_id;
      pat_d       = pat_q;
      shift_d     = shift;
      fill_d      = fill;
      bit_cnt_d   = bit_cnt;
      gnt_d       = gnt;
      busy_d      = busy;
      done_d      = 1'b0;
      hit_d       = hit;
      match_pos_d = match_pos;
      done_id_d   = done_id;

      case (state)
         IDLE: begin
            if (arb_found) begin
               gnt_d         = '0;
               gnt_d[arb_id] = 1'b1;
               ptr_d         = arb_id;
               sess_id_d     = arb_id;
               pat_d         = pattern[int'(arb_id)*PAT_W +: PAT_W];
               shift_d       = '0;
               fill_d        = '0;
               bit_cnt_d     = '0;
               busy_d        = 1'b1;
               state_d       = HUNT;
            end
         end

         HUNT: begin
            if (abort_w) begin
               // Abort wins over everything and leaves the din bit unconsumed.
               state_d     = DONE;
               done_d      = 1'b1;
               hit_d       = 1'b0;
               match_pos_d = bit_cnt;
               done_id_d   = sess_id;
            end else if (din_valid) begin
               shift_d   = window;
               fill_d    = (fill == FILL_MAX) ? fill : fill + FILL_W'(1);
               bit_cnt_d = bit_cnt + POS_W'(1);
               // A match on the final allowed bit takes priority over timeout.
               if (fill >= FILL_MIN && window == pat_q) begin
                  state_d     = DONE;
                  done_d      = 1'b1;
                  hit_d       = 1'b1;
                  match_pos_d = bit_cnt;
                  done_id_d   = sess_id;
               end else if (bit_cnt == LAST_BIT) begin
                  state_d     = DONE;
                  done_d      = 1'b1;
                  hit_d       = 1'b0;
                  match_pos_d = LAST_BIT;
                  done_id_d   = sess_id;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= ID_W'(N_REQ - 1);
         sess_id   <= '0;
         pat_q     <= '0;
         shift     <= '0;
         fill      <= '0;
         bit_cnt   <= '0;
         gnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         hit       <= 1'b0;
         match_pos <= '0;
         done_id   <= '0;
      end else begin
         state     <= state_d;
         ptr       <= ptr_d;
         sess_id   <= sess_id_d;
         pat_q     <= pat_d;
         shift     <= shift_d;
         fill      <= fill_d;
         bit_cnt   <= bit_cnt_d;
         gnt       <= gnt_d;
         busy      <= busy_d;
         done      <= done_d;
         hit       <= hit_d;
         match_pos <= match_pos_d;
         done_id   <= done_id_d;
      end
   end

endmodule
